// File: rtl/conv_encoder_sys.sv
// conv_encoder_sys
// ----------------
// Rate-1/2 feed-forward convolutional encoder with per-frame constraint
// length K in 3..6. Each accepted data bit produces one 2-bit symbol on the
// next cycle. After the last data bit, K-1 zero tail bits are injected so
// the trellis ends in state 0. The final tail symbol carries sym_last.
//
// Ports:
//   clk, rst                  rising-edge clock, async active-high reset
//   choose_constraint_length  K for the next frame, sampled on its first bit
//   in_bit/in_valid/in_last   data bit stream (in_ready handshake)
//   in_ready                  encoder can take in_bit this cycle
//   encoded_bits              {G0 output, G1 output}
//   sym_valid/sym_last        symbol stream (sym_ready handshake)
//   sym_count                 symbols emitted this frame, incl. the one shown
//   cfg_err                   one-cycle pulse after an out-of-range K is latched
module conv_encoder_sys #(
  parameter int MAX_K = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       choose_constraint_length,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [1:0]       encoded_bits,
  output logic             sym_valid,
  output logic             sym_last,
  input  logic             sym_ready,
  output logic [CNT_W-1:0] sym_count,
  output logic             cfg_err
);

  localparam int SR_W = MAX_K - 1;

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  state_t           state, next_state;
  logic [SR_W-1:0]  sr;
  logic [2:0]       k_lat;
  logic [2:0]       tail_cnt;

  logic             slot_free;
  logic             in_xfer;
  logic             emit;
  logic             start_frame;
  logic             last_tail;
  logic             shift_u;
  logic             k_bad;
  logic [2:0]       k_use;
  logic [SR_W-1:0]  sr_use;
  logic [MAX_K-1:0] window;
  logic [MAX_K-1:0] g0;
  logic [MAX_K-1:0] g1;

  // Generator taps are left-aligned so bit MAX_K-1 always taps the current
  // input; older shift-register stages beyond K-2 fall on zero taps.
  function automatic logic [MAX_K-1:0] taps_g0(input logic [2:0] k);
    case (k)
      3'd3:    taps_g0 = 6'b111000;
      3'd4:    taps_g0 = 6'b111100;
      3'd5:    taps_g0 = 6'b100110;
      default: taps_g0 = 6'b101011;
    endcase
  endfunction

  function automatic logic [MAX_K-1:0] taps_g1(input logic [2:0] k);
    case (k)
      3'd3:    taps_g1 = 6'b101000;
      3'd4:    taps_g1 = 6'b110100;
      3'd5:    taps_g1 = 6'b111010;
      default: taps_g1 = 6'b111101;
    endcase
  endfunction

  function automatic logic [2:0] clamp_k(input logic [2:0] c);
    if (c < 3'd3)
      clamp_k = 3'd3;
    else if (c == 3'd7)
      clamp_k = 3'd6;
    else
      clamp_k = c;
  endfunction

  assign slot_free = !sym_valid || sym_ready;
  assign in_ready  = !rst && (state == IDLE || state == DATA) && slot_free;
  assign in_xfer   = in_valid && in_ready;
  assign k_bad     = (choose_constraint_length < 3'd3) ||
                     (choose_constraint_length == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state  = state;
    emit        = 1'b0;
    start_frame = 1'b0;
    last_tail   = 1'b0;
    shift_u     = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_xfer) begin
          emit        = 1'b1;
          start_frame = 1'b1;
          shift_u     = in_bit;
          next_state  = in_last ? TAIL : DATA;
        end
      end
      DATA: begin
        if (in_xfer) begin
          emit    = 1'b1;
          shift_u = in_bit;
          if (in_last)
            next_state = TAIL;
        end
      end
      TAIL: begin
        // The last tail symbol leaves for IDLE right away; IDLE's in_ready
        // still waits for that symbol to transfer before taking a new bit.
        if (slot_free) begin
          emit = 1'b1;
          if (tail_cnt <= 3'd1) begin
            last_tail  = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The first bit of a frame uses the freshly clamped K and an all-zero
  // history, so the frame never depends on leftovers from a previous one.
  always_comb begin
    k_use  = start_frame ? clamp_k(choose_constraint_length) : k_lat;
    sr_use = start_frame ? '0 : sr;
    g0     = taps_g0(k_use);
    g1     = taps_g1(k_use);
    window = '0;
    window[MAX_K-1] = shift_u;
    for (int i = 0; i < SR_W; i++)
      window[MAX_K-2-i] = sr_use[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      encoded_bits <= 2'b00;
      sym_valid    <= 1'b0;
      sym_last     <= 1'b0;
      sym_count    <= '0;
      cfg_err      <= 1'b0;
      sr           <= '0;
      tail_cnt     <= 3'd0;
      k_lat        <= 3'd3;
    end else begin
      cfg_err <= 1'b0;
      if (emit) begin
        encoded_bits <= {^(window & g0), ^(window & g1)};
        sym_valid    <= 1'b1;
        sym_last     <= last_tail;
        sr           <= {sr_use[SR_W-2:0], shift_u};
        if (start_frame)
          sym_count <= CNT_W'(1);
        else if (sym_count != '1)
          sym_count <= sym_count + CNT_W'(1);
      end else if (sym_ready) begin
        sym_valid <= 1'b0;
        sym_last  <= 1'b0;
      end

      if (start_frame) begin
        k_lat   <= k_use;
        cfg_err <= k_bad;
      end

      if (in_xfer && in_last)
        tail_cnt <= k_use - 3'd1;
      else if (state == TAIL && emit)
        tail_cnt <= tail_cnt - 3'd1;

      if (last_tail)
        sr <= '0;
    end
  end

endmodule

// File: tb/tb_conv_encoder_sys.sv
// tb_conv_encoder_sys
// -------------------
// Self-checking bench for conv_encoder_sys: a table of directed frames with
// hand-derived symbol sequences, a stalled-output sequence, reset during the
// tail, and random frames against a convolution reference model.
module tb_conv_encoder_sys;

  localparam int CNT_W = 16;
  localparam int NVEC  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       choose_constraint_length;
  logic             in_bit;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [1:0]       encoded_bits;
  logic             sym_valid;
  logic             sym_last;
  logic             sym_ready;
  logic [CNT_W-1:0] sym_count;
  logic             cfg_err;

  conv_encoder_sys #(.MAX_K(6), .CNT_W(CNT_W)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .choose_constraint_length (choose_constraint_length),
    .in_bit                   (in_bit),
    .in_valid                 (in_valid),
    .in_last                  (in_last),
    .in_ready                 (in_ready),
    .encoded_bits             (encoded_bits),
    .sym_valid                (sym_valid),
    .sym_last                 (sym_last),
    .sym_ready                (sym_ready),
    .sym_count                (sym_count),
    .cfg_err                  (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       b;
    logic       last;
    logic       first;
    logic [2:0] kc;
  } in_item_t;

  typedef struct {
    logic [1:0]       bits;
    logic             last;
    logic [CNT_W-1:0] cnt;
  } sym_t;

  typedef struct {
    logic [2:0]  kc;
    int          nbits;
    logic [15:0] data;
    int          nsym;
    logic [31:0] syms;
    int          nerr;
  } vec_t;

  in_item_t in_q[$];
  sym_t     exp_q[$];
  sym_t     got_q[$];
  vec_t     vecs[NVEC];
  vec_t     post_rst;

  int checks   = 0;
  int errors   = 0;
  int cfg_seen = 0;
  int exp_cfg  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: octal generators per K, symbol n is the convolution of
  // the zero-extended data sequence with each generator's impulse response.
  function automatic logic [5:0] gen_of(input int k, input int which);
    logic [5:0] g;
    case (k)
      3:       g = (which == 0) ? 6'o07 : 6'o05;
      4:       g = (which == 0) ? 6'o17 : 6'o15;
      5:       g = (which == 0) ? 6'o23 : 6'o35;
      default: g = (which == 0) ? 6'o53 : 6'o75;
    endcase
    return g;
  endfunction

  function automatic int clamp_k(input logic [2:0] c);
    if (c < 3'd3) return 3;
    if (c == 3'd7) return 6;
    return int'(c);
  endfunction

  task automatic model_frame(input logic [2:0] kc, input int nbits,
                             input logic [31:0] data);
    int k;
    int total;
    logic [5:0] g0;
    logic [5:0] g1;
    in_item_t it;
    sym_t s;
    k     = clamp_k(kc);
    total = nbits + k - 1;
    g0    = gen_of(k, 0);
    g1    = gen_of(k, 1);
    for (int i = 0; i < nbits; i++) begin
      it.b     = data[i];
      it.last  = (i == nbits - 1);
      it.first = (i == 0);
      it.kc    = kc;
      in_q.push_back(it);
    end
    for (int n = 0; n < total; n++) begin
      logic o0;
      logic o1;
      logic x;
      o0 = 1'b0;
      o1 = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (n - j >= 0) begin
          x = (n - j < nbits) ? data[n-j] : 1'b0;
          if (g0[k-1-j]) o0 = o0 ^ x;
          if (g1[k-1-j]) o1 = o1 ^ x;
        end
      end
      s.bits = {o0, o1};
      s.last = (n == total - 1);
      s.cnt  = CNT_W'(n + 1);
      exp_q.push_back(s);
    end
    if (kc < 3'd3 || kc == 3'd7)
      exp_cfg++;
  endtask

  // mode 0: sym_ready always 1; mode 1: random handshakes on both sides;
  // mode 2: ready except a 3-cycle stall while the 2nd symbol is shown.
  task automatic applyStimulus(input int mode, input int target,
                               input int max_cycles);
    int cyc = 0;
    int stall_left = 0;
    bit stall_started = 0;
    bit held = 0;
    sym_t held_sym;
    sym_t s;
    in_item_t head;
    held_sym = '{2'b00, 1'b0, '0};
    @(negedge clk);
    while (!(in_q.size() == 0 && got_q.size() >= target)) begin
      if (cyc >= max_cycles) begin
        checks++;
        errors++;
        $display("[TB] FAIL timeout: got %0d symbols, expected %0d",
                 got_q.size(), target);
        break;
      end
      if (mode == 2 && !stall_started && got_q.size() == 1 && sym_valid) begin
        stall_started = 1;
        stall_left    = 3;
      end
      if (stall_left > 0)
        sym_ready = 1'b0;
      else if (mode == 1)
        sym_ready = ($urandom_range(0, 9) < 7);
      else
        sym_ready = 1'b1;
      if (in_q.size() > 0) begin
        head     = in_q[0];
        in_valid = (mode == 1) ? ($urandom_range(0, 4) != 0) : 1'b1;
        in_bit   = head.b;
        in_last  = head.last;
        choose_constraint_length = head.first ? head.kc
                                              : 3'($urandom_range(0, 7));
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      #1;
      if (held) begin
        checkOutput("hold_valid", 32'(sym_valid), 32'd1);
        checkOutput("hold_bits", 32'(encoded_bits), 32'(held_sym.bits));
        checkOutput("hold_last", 32'(sym_last), 32'(held_sym.last));
        checkOutput("hold_count", 32'(sym_count), 32'(held_sym.cnt));
      end
      if (stall_left > 0) begin
        checkOutput("stall_bits", 32'(encoded_bits), 32'b10);
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        stall_left--;
      end
      if (cfg_err) cfg_seen++;
      s.bits = encoded_bits;
      s.last = sym_last;
      s.cnt  = sym_count;
      if (sym_valid && sym_ready) got_q.push_back(s);
      held     = sym_valid && !sym_ready;
      held_sym = s;
      if (in_valid && in_ready) void'(in_q.pop_front());
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic compareSyms(input string tag);
    int n;
    checkOutput($sformatf("%s_nsym", tag), 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_sym%0d_bits", tag, i),
                  32'(got_q[i].bits), 32'(exp_q[i].bits));
      checkOutput($sformatf("%s_sym%0d_last", tag, i),
                  32'(got_q[i].last), 32'(exp_q[i].last));
      checkOutput($sformatf("%s_sym%0d_count", tag, i),
                  32'(got_q[i].cnt), 32'(exp_q[i].cnt));
    end
  endtask

  task automatic idleCheck(input string tag);
    in_valid  = 1'b0;
    sym_ready = 1'b1;
    #1;
    checkOutput($sformatf("%s_idle_valid", tag), 32'(sym_valid), 32'd0);
    checkOutput($sformatf("%s_idle_in_ready", tag), 32'(in_ready), 32'd1);
  endtask

  task automatic clearQueues();
    in_q.delete();
    exp_q.delete();
    got_q.delete();
    cfg_seen = 0;
  endtask

  task automatic runDirected(input vec_t v, input string tag, input int mode);
    in_item_t it;
    sym_t s;
    clearQueues();
    for (int i = 0; i < v.nbits; i++) begin
      it.b     = v.data[i];
      it.last  = (i == v.nbits - 1);
      it.first = (i == 0);
      it.kc    = v.kc;
      in_q.push_back(it);
    end
    for (int i = 0; i < v.nsym; i++) begin
      s.bits = v.syms[2*i +: 2];
      s.last = (i == v.nsym - 1);
      s.cnt  = CNT_W'(i + 1);
      exp_q.push_back(s);
    end
    applyStimulus(mode, v.nsym, 2000);
    compareSyms(tag);
    checkOutput($sformatf("%s_cfg_err", tag), 32'(cfg_seen), 32'(v.nerr));
    idleCheck(tag);
  endtask

  initial begin
    logic [2:0]  kc;
    int          nb;
    logic [31:0] d;

    // symbol i sits at syms[2i+1:2i] as {G0, G1}
    vecs[0] = '{3'd3, 4, 16'b1101,   6,  32'b110101001011, 0};
    vecs[1] = '{3'd3, 1, 16'b1,      3,  32'b111011,       0};
    vecs[2] = '{3'd6, 6, 16'b000001, 11, 32'b111001110111, 0};
    vecs[3] = '{3'd4, 1, 16'b1,      4,  32'b11101111,     0};
    vecs[4] = '{3'd5, 1, 16'b1,      5,  32'b1110010111,   0};
    vecs[5] = '{3'd7, 6, 16'b000001, 11, 32'b111001110111, 1};
    vecs[6] = '{3'd2, 4, 16'b1101,   6,  32'b110101001011, 1};
    vecs[7] = '{3'd0, 1, 16'b1,      3,  32'b111011,       1};
    post_rst = '{3'd3, 2, 16'b01,    4,  32'b00111011,     0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_last   = 1'b0;
    sym_ready = 1'b0;
    choose_constraint_length = 3'd3;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_sym_valid", 32'(sym_valid), 32'd0);
    checkOutput("rst_bits", 32'(encoded_bits), 32'd0);
    checkOutput("rst_count", 32'(sym_count), 32'd0);
    checkOutput("rst_last", 32'(sym_last), 32'd0);
    checkOutput("rst_cfg_err", 32'(cfg_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NVEC; i++)
      runDirected(vecs[i], $sformatf("vec%0d", i), 0);

    runDirected(vecs[0], "stall", 2);
    runDirected(vecs[2], "k6_rand_hs", 1);

    // Reset in the middle of a K=5 tail: outputs must clear at once and the
    // following frame must start from a clean history.
    clearQueues();
    model_frame(3'd5, 2, 32'b11);
    applyStimulus(0, 3, 2000);
    checkOutput("tail_before_rst_valid", 32'(sym_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 32'(sym_valid), 32'd0);
    checkOutput("midrst_bits", 32'(encoded_bits), 32'd0);
    checkOutput("midrst_last", 32'(sym_last), 32'd0);
    checkOutput("midrst_count", 32'(sym_count), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    clearQueues();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_release_in_ready", 32'(in_ready), 32'd1);
    runDirected(post_rst, "post_rst", 0);

    // Random back-to-back frames against the reference model
    clearQueues();
    exp_cfg = 0;
    for (int f = 0; f < 25; f++) begin
      kc = 3'($urandom_range(0, 7));
      nb = $urandom_range(1, 12);
      d  = $urandom;
      model_frame(kc, nb, d);
    end
    applyStimulus(1, exp_q.size(), 20000);
    compareSyms("rand");
    checkOutput("rand_cfg_err", 32'(cfg_seen), 32'(exp_cfg));
    idleCheck("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
